eth_tx_frame_arbiter: RTL and testbench

Frame-level round-robin arbiter that shares the single TX AXI-stream input of the 1G RGMII MAC-with-FIFO between several requesters in the logic clock domain. A grant is held for a whole frame, from first beat to `tlast`, so frames are never interleaved. A per-frame beat limit truncates runaway frames: the arbiter marks them bad via `tuser`, so the TX frame FIFO drops them, and then drains the rest of the frame from the offending source.

---
 rtl/eth_rr_pick.sv | 31 +++
 rtl/eth_tx_frame_arbiter.sv | 166 ++++++++++++++++
 tb/tb_eth_tx_frame_arbiter.sv | 327 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/eth_rr_pick.sv
`default_nettype none
// eth_rr_pick: rotate-priority one-hot selector. The search starts at last_i+1 and wraps.
module eth_rr_pick #(
  parameter int PORTS = 2,
  parameter int IDX_W = $clog2(PORTS)
) (
  input  logic [PORTS-1:0] req_i,
  input  logic [IDX_W-1:0] last_i,
  output logic [PORTS-1:0] gnt_o,
  output logic [IDX_W-1:0] idx_o
);

  logic found;

  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    found = 1'b0;
    for (int k = 1; k <= PORTS; k++) begin
      for (int i = 0; i < PORTS; i++) begin
        if (!found && req_i[i] && (i == ((int'(last_i) + k) % PORTS))) begin
          found    = 1'b1;
          gnt_o[i] = 1'b1;
          idx_o    = IDX_W'(i);
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/eth_tx_frame_arbiter.sv
`default_nettype none
// eth_tx_frame_arbiter: frame-level round-robin arbiter onto the MAC TX AXI-stream input.
// Frames longer than MAX_FRAME_BEATS are cut, flagged bad through tuser, and the remainder is drained.
module eth_tx_frame_arbiter #(
  parameter int PORTS           = 2,
  parameter int DATA_WIDTH      = 8,
  parameter int KEEP_WIDTH      = DATA_WIDTH / 8,
  parameter int MAX_FRAME_BEATS = 1518,
  parameter int CNT_WIDTH       = $clog2(MAX_FRAME_BEATS + 1)
) (
  input  logic                        logic_clk,
  input  logic                        logic_rst_n,
  input  logic [PORTS-1:0]            s_port_en,
  input  logic [PORTS*DATA_WIDTH-1:0] s_axis_tdata,
  input  logic [PORTS*KEEP_WIDTH-1:0] s_axis_tkeep,
  input  logic [PORTS-1:0]            s_axis_tvalid,
  input  logic [PORTS-1:0]            s_axis_tlast,
  input  logic [PORTS-1:0]            s_axis_tuser,
  output logic [PORTS-1:0]            s_axis_tready,
  output logic [DATA_WIDTH-1:0]       m_axis_tdata,
  output logic [KEEP_WIDTH-1:0]       m_axis_tkeep,
  output logic                        m_axis_tvalid,
  output logic                        m_axis_tlast,
  output logic                        m_axis_tuser,
  input  logic                        m_axis_tready,
  output logic [PORTS-1:0]            grant,
  output logic                        busy,
  output logic                        truncated
);

  localparam int IDX_W = $clog2(PORTS);
  localparam logic [CNT_WIDTH-1:0] LIMIT = CNT_WIDTH'(MAX_FRAME_BEATS - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PASS  = 2'd1,
    DRAIN = 2'd2
  } state_e;

  state_e                 state_q;
  logic [PORTS-1:0]       grant_q;
  logic [IDX_W-1:0]       last_q;
  logic [CNT_WIDTH-1:0]   cnt_q;
  logic [CNT_WIDTH-1:0]   cnt_d;
  logic                   busy_q;
  logic                   trunc_q;

  logic [PORTS-1:0]       req;
  logic [PORTS-1:0]       pick_gnt;
  logic [IDX_W-1:0]       pick_idx;

  logic [DATA_WIDTH-1:0]  src_data;
  logic [KEEP_WIDTH-1:0]  src_keep;
  logic                   src_valid;
  logic                   src_last;
  logic                   src_user;

  logic                   in_pass;
  logic                   in_drain;
  logic                   at_limit;
  logic                   out_valid;
  logic                   accept;
  logic                   drain_acc;

  assign req = s_axis_tvalid & s_port_en;

  eth_rr_pick #(
    .PORTS (PORTS),
    .IDX_W (IDX_W)
  ) u_pick (
    .req_i  (req),
    .last_i (last_q),
    .gnt_o  (pick_gnt),
    .idx_o  (pick_idx)
  );

  // grant_q is one-hot or zero, so an OR of masked slices is a clean mux.
  always_comb begin
    src_data  = '0;
    src_keep  = '0;
    src_valid = 1'b0;
    src_last  = 1'b0;
    src_user  = 1'b0;
    for (int i = 0; i < PORTS; i++) begin
      if (grant_q[i]) begin
        src_data  = s_axis_tdata[i*DATA_WIDTH +: DATA_WIDTH];
        src_keep  = s_axis_tkeep[i*KEEP_WIDTH +: KEEP_WIDTH];
        src_valid = s_axis_tvalid[i];
        src_last  = s_axis_tlast[i];
        src_user  = s_axis_tuser[i];
      end
    end
  end

  assign in_pass   = (state_q == PASS);
  assign in_drain  = (state_q == DRAIN);
  assign at_limit  = (cnt_q == LIMIT);
  assign out_valid = in_pass & src_valid;
  assign accept    = out_valid & m_axis_tready;
  assign drain_acc = in_drain & src_valid;
  assign cnt_d     = cnt_q + 1'b1;

  assign m_axis_tvalid = out_valid;
  assign m_axis_tdata  = out_valid ? src_data : '0;
  assign m_axis_tkeep  = out_valid ? src_keep : '0;
  assign m_axis_tlast  = out_valid & (src_last | at_limit);
  assign m_axis_tuser  = out_valid & (src_user | (at_limit & ~src_last));

  assign s_axis_tready = in_pass  ? (grant_q & {PORTS{m_axis_tready}}) :
                         in_drain ? grant_q : '0;

  assign grant     = grant_q;
  assign busy      = busy_q;
  assign truncated = trunc_q;

  always_ff @(posedge logic_clk or negedge logic_rst_n) begin
    if (!logic_rst_n) begin
      state_q <= IDLE;
      grant_q <= '0;
      last_q  <= IDX_W'(PORTS - 1);
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      trunc_q <= 1'b0;
    end else begin
      trunc_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (|req) begin
            grant_q <= pick_gnt;
            last_q  <= pick_idx;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= PASS;
          end
        end
        PASS: begin
          if (accept) begin
            cnt_q <= cnt_d;
            if (src_last) begin
              grant_q <= '0;
              busy_q  <= 1'b0;
              state_q <= IDLE;
            end else if (at_limit) begin
              trunc_q <= 1'b1;
              state_q <= DRAIN;
            end
          end
        end
        DRAIN: begin
          if (drain_acc && src_last) begin
            grant_q <= '0;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: begin
          grant_q <= '0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_eth_tx_frame_arbiter.sv
`default_nettype none
// tb_eth_tx_frame_arbiter: vector table for cycle-exact behaviour plus queue-based frame
// streams checked against a frame-order reference model.
module tb_eth_tx_frame_arbiter;

  localparam int P    = 2;
  localparam int DW   = 8;
  localparam int KW   = 1;
  localparam int MAXB = 16;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [P-1:0]    s_port_en;
  logic [P*DW-1:0] s_axis_tdata;
  logic [P*KW-1:0] s_axis_tkeep;
  logic [P-1:0]    s_axis_tvalid;
  logic [P-1:0]    s_axis_tlast;
  logic [P-1:0]    s_axis_tuser;
  logic [P-1:0]    s_axis_tready;
  logic [DW-1:0]   m_axis_tdata;
  logic [KW-1:0]   m_axis_tkeep;
  logic            m_axis_tvalid;
  logic            m_axis_tlast;
  logic            m_axis_tuser;
  logic            m_axis_tready;
  logic [P-1:0]    grant;
  logic            busy;
  logic            truncated;

  eth_tx_frame_arbiter #(
    .PORTS           (P),
    .DATA_WIDTH      (DW),
    .KEEP_WIDTH      (KW),
    .MAX_FRAME_BEATS (MAXB)
  ) dut (
    .logic_clk     (clk),
    .logic_rst_n   (rst_n),
    .s_port_en     (s_port_en),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tkeep  (s_axis_tkeep),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tlast  (s_axis_tlast),
    .s_axis_tuser  (s_axis_tuser),
    .s_axis_tready (s_axis_tready),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tkeep  (m_axis_tkeep),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tlast  (m_axis_tlast),
    .m_axis_tuser  (m_axis_tuser),
    .m_axis_tready (m_axis_tready),
    .grant         (grant),
    .busy          (busy),
    .truncated     (truncated)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic [7:0] data;
    logic       keep;
    logic       last;
    logic       user;
    logic       first;
  } beat_t;

  typedef struct packed {
    logic [1:0] grant;
    logic [7:0] data;
    logic       keep;
    logic       last;
    logic       user;
  } obs_t;

  typedef struct packed {
    logic [1:0] en, vld, lst, usr;
    logic       mrdy;
    logic [1:0] e_grant;
    logic       e_mvalid;
    logic [7:0] e_mdata;
    logic       e_mlast, e_muser;
    logic [1:0] e_sready;
    logic       e_busy, e_trunc;
  } vec_t;

  beat_t q0[$];
  beat_t q1[$];
  int    fl0[$];
  int    fl1[$];
  obs_t  expq[$];
  int    model_last;
  int    exp_trunc;
  vec_t  tbl[12];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic add_frame(input int p, input int len, input logic ulast);
    beat_t b;
    for (int i = 0; i < len; i++) begin
      b.data  = 8'($urandom);
      b.keep  = 1'($urandom);
      b.last  = (i == len - 1);
      b.user  = b.last ? ulast : 1'($urandom);
      b.first = (i == 0);
      if (p == 0) q0.push_back(b); else q1.push_back(b);
    end
    if (p == 0) fl0.push_back(len); else fl1.push_back(len);
  endtask

  // Reference: backlogged ports are served round-robin frame by frame; each frame is
  // cut to MAXB beats, the cut beat carrying last=1 and user=1.
  task automatic build_expected();
    beat_t b0[$];
    beat_t b1[$];
    beat_t b;
    obs_t  e;
    int    p;
    int    len;
    b0 = q0;
    b1 = q1;
    exp_trunc = 0;
    while (fl0.size() > 0 || fl1.size() > 0) begin
      p = (model_last + 1) % P;
      if (p == 0 && fl0.size() == 0) p = 1;
      else if (p == 1 && fl1.size() == 0) p = 0;
      model_last = p;
      len = (p == 0) ? fl0.pop_front() : fl1.pop_front();
      for (int i = 0; i < len; i++) begin
        b = (p == 0) ? b0.pop_front() : b1.pop_front();
        if (i < MAXB) begin
          e.grant = 2'(1 << p);
          e.data  = b.data;
          e.keep  = b.keep;
          e.last  = b.last;
          e.user  = b.user;
          if (i == MAXB - 1 && len > MAXB) begin
            e.last = 1'b1;
            e.user = 1'b1;
            exp_trunc++;
          end
          expq.push_back(e);
        end
      end
    end
  endtask

  task automatic drive_port(input int p, input logic v, input beat_t b);
    s_axis_tvalid[p]       = v;
    s_axis_tdata[p*DW +: DW] = b.data;
    s_axis_tkeep[p]        = b.keep;
    s_axis_tlast[p]        = b.last;
    s_axis_tuser[p]        = b.user;
  endtask

  task automatic run_stream(input bit rnd, input string name);
    beat_t b;
    obs_t  o;
    obs_t  e;
    logic  acc0;
    logic  acc1;
    logic  v;
    logic  inv_bad;
    int    tcnt;
    int    cyc;
    build_expected();
    acc0 = 1'b0;
    acc1 = 1'b0;
    inv_bad = 1'b0;
    tcnt = 0;
    cyc = 0;
    s_port_en = 2'b11;
    while (cyc < 4000 && !(q0.size() == 0 && q1.size() == 0 && expq.size() == 0)) begin
      @(posedge clk); #1;
      if (acc0) void'(q0.pop_front());
      if (acc1) void'(q1.pop_front());
      for (int p = 0; p < P; p++) begin
        if ((p == 0 ? q0.size() : q1.size()) > 0) begin
          b = (p == 0) ? q0[0] : q1[0];
          v = b.first || !rnd || ($urandom_range(0, 3) != 0);
        end else begin
          b = beat_t'($urandom);
          v = 1'b0;
        end
        drive_port(p, v, b);
      end
      m_axis_tready = !rnd || ($urandom_range(0, 2) != 0);
      @(negedge clk);
      acc0 = s_axis_tvalid[0] & s_axis_tready[0];
      acc1 = s_axis_tvalid[1] & s_axis_tready[1];
      if (truncated) tcnt++;
      if (!m_axis_tvalid && (m_axis_tdata != 0 || m_axis_tkeep != 0 || m_axis_tlast || m_axis_tuser))
        inv_bad = 1'b1;
      if ((s_axis_tready & ~grant) != 0 || !$onehot0(grant)) inv_bad = 1'b1;
      if (m_axis_tvalid && m_axis_tready) begin
        o = {grant, m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_tuser};
        if (expq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL %s_extra_beat: got %h expected none", name, o);
        end else begin
          e = expq.pop_front();
          check({name, "_beat"}, 64'(o), 64'(e));
        end
      end
      cyc++;
    end
    check({name, "_done"}, 64'(q0.size() + q1.size() + expq.size()), 64'd0);
    s_axis_tvalid = '0;
    m_axis_tready = 1'b1;
    repeat (2) begin
      @(negedge clk);
      if (truncated) tcnt++;
    end
    check({name, "_trunc_count"}, 64'(tcnt), 64'(exp_trunc));
    check({name, "_invariants"}, 64'(inv_bad), 64'd0);
    check({name, "_idle_busy"}, 64'({busy, grant}), 64'd0);
    q0.delete();
    q1.delete();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    s_port_en = '0;
    s_axis_tdata = '0;
    s_axis_tkeep = '0;
    s_axis_tvalid = '0;
    s_axis_tlast = '0;
    s_axis_tuser = '0;
    m_axis_tready = 1'b0;
    model_last = P - 1;

    //           en     vld    lst    usr    rdy | grant  mv  mdata  ml  mu  srdy  busy tr
    tbl[0]  = '{2'b11, 2'b00, 2'b00, 2'b00, 1'b1, 2'b00, 1'b0, 8'h00, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0};
    tbl[1]  = '{2'b10, 2'b11, 2'b00, 2'b00, 1'b1, 2'b00, 1'b0, 8'h00, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0};
    tbl[2]  = '{2'b00, 2'b11, 2'b00, 2'b00, 1'b1, 2'b10, 1'b1, 8'h22, 1'b0, 1'b0, 2'b10, 1'b1, 1'b0};
    tbl[3]  = '{2'b00, 2'b11, 2'b10, 2'b10, 1'b0, 2'b10, 1'b1, 8'h22, 1'b1, 1'b1, 2'b00, 1'b1, 1'b0};
    tbl[4]  = '{2'b00, 2'b11, 2'b10, 2'b10, 1'b1, 2'b10, 1'b1, 8'h22, 1'b1, 1'b1, 2'b10, 1'b1, 1'b0};
    tbl[5]  = '{2'b11, 2'b11, 2'b00, 2'b00, 1'b1, 2'b00, 1'b0, 8'h00, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0};
    tbl[6]  = '{2'b11, 2'b11, 2'b01, 2'b00, 1'b1, 2'b01, 1'b1, 8'h11, 1'b1, 1'b0, 2'b01, 1'b1, 1'b0};
    tbl[7]  = '{2'b11, 2'b00, 2'b00, 2'b00, 1'b1, 2'b00, 1'b0, 8'h00, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0};
    tbl[8]  = '{2'b11, 2'b10, 2'b00, 2'b00, 1'b1, 2'b00, 1'b0, 8'h00, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0};
    tbl[9]  = '{2'b11, 2'b00, 2'b00, 2'b00, 1'b1, 2'b10, 1'b0, 8'h00, 1'b0, 1'b0, 2'b10, 1'b1, 1'b0};
    tbl[10] = '{2'b11, 2'b10, 2'b10, 2'b01, 1'b1, 2'b10, 1'b1, 8'h22, 1'b1, 1'b0, 2'b10, 1'b1, 1'b0};
    tbl[11] = '{2'b11, 2'b00, 2'b00, 2'b00, 1'b1, 2'b00, 1'b0, 8'h00, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0};

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_state",
          64'({grant, busy, truncated, m_axis_tvalid, s_axis_tready, m_axis_tdata, m_axis_tlast, m_axis_tuser}),
          64'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      s_port_en     = tbl[i].en;
      s_axis_tvalid = tbl[i].vld;
      s_axis_tlast  = tbl[i].lst;
      s_axis_tuser  = tbl[i].usr;
      s_axis_tdata  = 16'h2211;
      s_axis_tkeep  = 2'b11;
      m_axis_tready = tbl[i].mrdy;
      @(negedge clk);
      check($sformatf("vec%0d", i),
            64'({grant, m_axis_tvalid, m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_tuser,
                 s_axis_tready, busy, truncated}),
            64'({tbl[i].e_grant, tbl[i].e_mvalid, tbl[i].e_mdata, tbl[i].e_mvalid, tbl[i].e_mlast,
                 tbl[i].e_muser, tbl[i].e_sready, tbl[i].e_busy, tbl[i].e_trunc}));
    end
    model_last = 1;

    add_frame(0, MAXB, 1'b1);
    add_frame(0, MAXB - 1, 1'b0);
    run_stream(1'b0, "exact_limit");

    add_frame(1, 20, 1'b0);
    add_frame(0, 6, 1'b0);
    run_stream(1'b0, "truncate");

    for (int f = 0; f < 10; f++) begin
      add_frame(0, $urandom_range(1, 22), 1'($urandom));
      add_frame(1, $urandom_range(1, 22), 1'($urandom));
    end
    run_stream(1'b1, "random");

    @(posedge clk); #1;
    s_port_en = 2'b11;
    s_axis_tvalid = 2'b01;
    s_axis_tlast = 2'b00;
    s_axis_tuser = 2'b00;
    s_axis_tdata = 16'h005A;
    s_axis_tkeep = 2'b01;
    m_axis_tready = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    check("rst_pre_frame", 64'({grant, busy, m_axis_tvalid}), 64'({2'b01, 1'b1, 1'b1}));
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_async",
          64'({grant, busy, truncated, m_axis_tvalid, s_axis_tready, m_axis_tdata, m_axis_tkeep,
               m_axis_tlast, m_axis_tuser}),
          64'd0);
    s_axis_tvalid = '0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
